input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Board-input front end for the Flippy Bit game.
- Sits between the raw DE0 pins (BUTTON, SW) and the top-level game logic.
- Synchronises and debounces the three push buttons and eight slide switches.
- Outputs clean levels plus single-cycle press/release/change pulses, so the game state machine and columns can consume a clean reset request and answer byte instead of bouncing asynchronous pins.

Parameters:
- NUM_BUTTONS, 3, number of push buttons (raw active-low).
- NUM_SWITCHES, 8, number of slide switches (raw active-high).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before an output changes (10 ms at 50 MHz); legal range >= 1.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  asynchronous, active-low reset
- button_raw  in  NUM_BUTTONS  raw button pins, 0 = pressed
- switch_raw  in  NUM_SWITCHES  raw switch pins
- button_level  out  NUM_BUTTONS  debounced state, 1 = pressed
- button_press  out  NUM_BUTTONS  one-cycle pulse on debounced press
- button_release  out  NUM_BUTTONS  one-cycle pulse on debounced release
- switch_value  out  NUM_SWITCHES  debounced switch word
- switch_changed  out  1  one-cycle pulse when any switch_value bit changes

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All synchroniser flops go to the idle value: buttons raw 1, switches 0.
  - All counters go to 0.
  - button_level = 0, button_press = 0, button_release = 0, switch_value = 0, switch_changed = 0.
- Synchroniser: 2 flops per input bit. Button bits are inverted after synchronisation, so the internal sense is 1 = pressed.
- Per-bit debounce filter. State: stable bit S and counter C, width $clog2(DEBOUNCE_CYCLES)+1.
  - sync == S: C <= 0.
  - sync != S and C < DEBOUNCE_CYCLES-1: C <= C+1.
  - sync != S and C == DEBOUNCE_CYCLES-1: S <= sync, C <= 0.
  - C never exceeds DEBOUNCE_CYCLES-1, and there is no wrap.
- Latency: S changes on exactly the (DEBOUNCE_CYCLES+2)th rising edge after, and including, the first edge that samples the new raw value, provided the raw value is held.
- Glitch rejection: any excursion at the synchroniser output shorter than DEBOUNCE_CYCLES cycles leaves S unchanged, and C returns to 0 when the input returns.
- Pulses:
  - button_press[i] is 1 for exactly the single cycle in which button_level[i] first reads 1.
  - button_release[i] is 1 for exactly the single cycle in which button_level[i] first reads 0.
  - Both are registered and never asserted together.
- switch_changed:
  - Asserted for one cycle, coincident with the first cycle switch_value shows a new word.
  - Several bits flipping on the same edge produce one pulse.
  - Bits flipping on consecutive edges produce consecutive pulses.
- Simultaneous events: each bit is filtered independently, with no priority between buttons; multiple press pulses may coincide.
- Reset mid-debounce: the partial count is discarded.
- After reset release, held inputs are debounced as fresh changes:
  - A button held through reset yields button_press after DEBOUNCE_CYCLES+2 cycles.
  - Switches up during reset yield one switch_changed with the full word.
- DEBOUNCE_CYCLES = 1: the filter degenerates to a one-cycle delay; latency is 3 edges.
- Outputs are purely registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - DEBOUNCE_CYCLES_DEFAULT = 500000.
  - CLOCK_HZ = 50_000_000.
  - A counter-width function, cnt_width(n) = $clog2(n)+1.
- One natural sub-module: debounce_bit.
  - Contents: 2-flop synchroniser, counter, stable bit, registered rise/fall pulses.
  - Parameters: DEBOUNCE_CYCLES and IDLE_VALUE.
  - Instantiated NUM_BUTTONS+NUM_SWITCHES times via generate.
  - The top wrapper handles button inversion and ORs the switch rise/fall pulses into switch_changed.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Reset: hold reset_n = 0 with button_raw = 3'b010 and switch_raw = 8'hA5 -> all outputs 0 during reset. After release: button_level = 3'b101 and switch_value = 8'hA5 on edge 6, one button_press = 3'b101 pulse, one switch_changed pulse.
- Bounce rejection: button_raw[0] low for 3 cycles, then high -> button_level[0] stays 0 and no pulses. Then hold low for 10 cycles -> button_level[0] = 1 on edge 6 and button_press[0] = 1 for exactly that cycle.
- Release: from pressed, raise button_raw[0] and hold -> button_release[0] pulses once on edge 6 and button_level[0] = 0 from then on.
- Multi-switch: switch_raw 8'h00 -> 8'h3C on one edge -> switch_value = 8'h3C on edge 6 with a single switch_changed pulse. Staggered change of bit 7 one cycle later -> a second pulse on the next cycle, switch_value = 8'hBC.
- Reset mid-operation: start a press, assert reset_n = 0 at count 2, release with the button still held -> no pulse before reset; button_press[0] pulses on edge 6 after release.
- Counter bound: hold button_raw[2] low for 50 cycles -> exactly one press pulse and C never exceeds 3 (assertion).

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the Flippy Bit input front end.
package input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CLOCK_HZ                = 50_000_000;

    // Counter width able to hold DEBOUNCE_CYCLES-1 with one bit of headroom.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter, stable level and
// registered rise/fall pulses that coincide with the level change.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit IDLE_VALUE      = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [W-1:0]   LIMIT = W'(DEBOUNCE_CYCLES - 1);

    logic         r_sync1;
    logic         r_sync2;
    logic         r_stable;
    logic         r_rise;
    logic         r_fall;
    logic [W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = (r_sync2 != r_stable);
    assign w_done = w_diff && (r_cnt == LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= IDLE_VALUE;
            r_sync2  <= IDLE_VALUE;
            r_stable <= IDLE_VALUE;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Pulses are launched on the same edge as the level so they line up.
            r_rise  <= w_done &  r_sync2;
            r_fall  <= w_done & ~r_sync2;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the DE0 push buttons (active-low pins) and slide switches and
// produces clean levels plus one-cycle press/release/change pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int NUM_SWITCHES    = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_BUTTONS-1:0]  button_raw,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_BUTTONS-1:0]  button_level,
    output logic [NUM_BUTTONS-1:0]  button_press,
    output logic [NUM_BUTTONS-1:0]  button_release,
    output logic [NUM_SWITCHES-1:0] switch_value,
    output logic                    switch_changed
);

    logic [NUM_BUTTONS-1:0]  w_btn_pin_level;
    logic [NUM_BUTTONS-1:0]  w_btn_rise;
    logic [NUM_BUTTONS-1:0]  w_btn_fall;
    logic [NUM_SWITCHES-1:0] w_sw_rise;
    logic [NUM_SWITCHES-1:0] w_sw_fall;

    genvar gi;

    // Buttons are filtered in pin sense (idle high); inversion happens below.
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_VALUE      (1'b1)
            ) u_db (
                .clock   (clock),
                .reset_n (reset_n),
                .i_raw   (button_raw[gi]),
                .o_level (w_btn_pin_level[gi]),
                .o_rise  (w_btn_rise[gi]),
                .o_fall  (w_btn_fall[gi])
            );
        end

        for (gi = 0; gi < NUM_SWITCHES; gi++) begin : g_sw
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_VALUE      (1'b0)
            ) u_db (
                .clock   (clock),
                .reset_n (reset_n),
                .i_raw   (switch_raw[gi]),
                .o_level (switch_value[gi]),
                .o_rise  (w_sw_rise[gi]),
                .o_fall  (w_sw_fall[gi])
            );
        end
    endgenerate

    // A falling pin is a press; a rising pin is a release.
    assign button_level   = ~w_btn_pin_level;
    assign button_press   = w_btn_fall;
    assign button_release = w_btn_rise;
    assign switch_changed = |(w_sw_rise | w_sw_fall);

endmodule
